// File: rtl/fp_norm_pkg.sv
// Shared types and constants for the fp_norm_round normalise/round pipeline.
package fp_norm_pkg;

  localparam int EMIN   = 1;
  localparam int FLAG_W = 4;

  typedef struct packed {
    logic ovf;
    logic unf;
    logic inexact;
    logic zero;
  } norm_flags_t;

endpackage

// File: rtl/fp_norm_round_rounder.sv
// Stage-2 combinational rounding and exponent fix-up for fp_norm_round.
// `FP_NORM_RNE_EN selects round-to-nearest-even; otherwise the mantissa is truncated.
module norm_rounder
  import fp_norm_pkg::*;
#(
  parameter int WIDTH = 24,
  parameter int EXP_W = 10,
  parameter int EXT   = 3
) (
  input  logic [WIDTH+EXT-1:0] man_s,
  input  logic [EXP_W-1:0]     exp_s,
  input  logic                 tiny,
  input  logic                 zero,
  output logic [WIDTH-1:0]     man,
  output logic [EXP_W-1:0]     exp,
  output norm_flags_t          flags
);

  // One extra exponent bit so a carry out of the top biased value is still visible.
  localparam logic [EXP_W:0] EXP_MAX = {1'b0, {EXP_W{1'b1}}};

  logic [WIDTH-1:0] kept;
  logic             inexact;
  logic [WIDTH-1:0] man_r;
  logic [EXP_W:0]   exp_r;
  logic             tiny_r;

  assign kept    = man_s[WIDTH+EXT-1:EXT];
  assign inexact = |man_s[EXT-1:0];

`ifdef FP_NORM_RNE_EN
  logic           g;
  logic           rs;
  logic           inc;
  logic [WIDTH:0] sum;

  always_comb begin
    g      = man_s[EXT-1];
    rs     = |man_s[EXT-2:0];
    inc    = g && (rs || kept[0]) && !zero;
    sum    = {1'b0, kept} + {{WIDTH{1'b0}}, inc};
    man_r  = sum[WIDTH-1:0];
    exp_r  = {1'b0, exp_s};
    tiny_r = tiny;
    if (sum[WIDTH]) begin
      man_r = {1'b1, {(WIDTH-1){1'b0}}};
      exp_r = exp_r + (EXP_W+1)'(1);
    end else if (tiny && sum[WIDTH-1]) begin
      // A subnormal that rounds up into the hidden bit becomes the smallest normal.
      exp_r  = (EXP_W+1)'(EMIN);
      tiny_r = 1'b0;
    end
  end
`else
  always_comb begin
    man_r  = kept;
    exp_r  = {1'b0, exp_s};
    tiny_r = tiny;
  end
`endif

  always_comb begin
    man           = man_r;
    exp           = exp_r[EXP_W-1:0];
    flags         = '0;
    flags.inexact = inexact;
    flags.zero    = zero;
    flags.unf     = tiny_r && inexact;
    if (exp_r >= EXP_MAX) begin
      flags.ovf = 1'b1;
      exp       = '1;
      man       = '0;
    end
  end

endmodule

// File: rtl/fp_norm_round.sv
// Two-stage normalise/round pipeline with valid/ready on both sides.
// Define FP_NORM_RNE_EN for round-to-nearest-even; default build truncates.
module fp_norm_round
  import fp_norm_pkg::*;
#(
  parameter int WIDTH = 24,
  parameter int EXP_W = 10,
  parameter int EXT   = 3
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       in_sign,
  input  logic [EXP_W-1:0]           in_exp,
  input  logic [WIDTH+EXT-1:0]       in_man,
  input  logic [$clog2(WIDTH):0]     in_lz,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       out_sign,
  output logic [EXP_W-1:0]           out_exp,
  output logic [WIDTH-1:0]           out_man,
  output logic [FLAG_W-1:0]          out_flags
);

  localparam int               LZ_W    = $clog2(WIDTH) + 1;
  localparam int               MW      = WIDTH + EXT;
  localparam logic [EXP_W-1:0] EMIN_E  = EXP_W'(EMIN);
  localparam logic [LZ_W-1:0]  LZ_ZERO = LZ_W'(WIDTH);

  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [MW-1:0]    man;
    logic             tiny;
    logic             zero;
  } s1_payload_t;

  logic             s1_v;
  logic             s2_v;
  logic             s2_adv;
  s1_payload_t      s1_d;
  s1_payload_t      s1_q;
  logic [EXP_W-1:0] lz_e;
  logic [EXP_W-1:0] span;
  logic [EXP_W-1:0] sh;
  logic [MW-1:0]    man_sh;
  logic [WIDTH-1:0] r_man;
  logic [EXP_W-1:0] r_exp;
  norm_flags_t      r_flags;

  assign s2_adv    = !s2_v || out_ready;
  assign in_ready  = !s1_v || s2_adv;
  assign out_valid = s2_v;

  // Stage 1: shift by lz, but never below EMIN; an all-zero mantissa is not shifted
  // so its G/R/S bits still report inexact.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no path
    // through the block leaves a variable unassigned, which would infer a latch.
    sh   = '0;
    lz_e = EXP_W'(in_lz);
    span = in_exp - EMIN_E;
    if (in_lz != LZ_ZERO && in_exp > EMIN_E) begin
      sh = (lz_e < span) ? lz_e : span;
    end
    man_sh    = in_man << sh;
    s1_d.sign = in_sign;
    s1_d.man  = man_sh;
    s1_d.zero = (in_lz == LZ_ZERO);
    s1_d.tiny = !man_sh[MW-1];
    s1_d.exp  = s1_d.tiny ? '0 : (in_exp - sh);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples the
  // pre-edge values, independent of the order the always_ff blocks are evaluated.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v <= 1'b0;
      // NOTE: payload registers are reset too; they are few, and it keeps the
      // pipeline contents deterministic after reset for debug.
      s1_q <= '0;
    end else if (in_ready) begin
      s1_v <= in_valid;
      if (in_valid) s1_q <= s1_d;
    end
  end

  norm_rounder #(
    .WIDTH (WIDTH),
    .EXP_W (EXP_W),
    .EXT   (EXT)
  ) u_rounder (
    .man_s (s1_q.man),
    .exp_s (s1_q.exp),
    .tiny  (s1_q.tiny),
    .zero  (s1_q.zero),
    .man   (r_man),
    .exp   (r_exp),
    .flags (r_flags)
  );

  // Stage 2 register doubles as the output; it only loads on a real beat so the
  // outputs hold while the consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_v      <= 1'b0;
      out_sign  <= 1'b0;
      out_exp   <= '0;
      out_man   <= '0;
      out_flags <= '0;
    end else if (s2_adv) begin
      s2_v <= s1_v;
      if (s1_v) begin
        out_sign  <= s1_q.sign;
        out_exp   <= r_exp;
        out_man   <= r_man;
        out_flags <= r_flags;
      end
    end
  end

endmodule

// File: tb/tb_fp_norm_round.sv
// Self-checking bench for fp_norm_round (WIDTH=24, EXP_W=10, EXT=3), both builds
// of FP_NORM_RNE_EN, against an arithmetic reference model.
module tb_fp_norm_round;

  typedef struct packed {
    logic        sign;
    logic [9:0]  exp;
    logic [26:0] man;
    logic [5:0]  lz;
  } vec_t;

  typedef struct packed {
    logic        sign;
    logic [9:0]  exp;
    logic [23:0] man;
    logic [3:0]  flags;
  } res_t;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic        in_sign;
  logic [9:0]  in_exp;
  logic [26:0] in_man;
  logic [5:0]  in_lz;
  logic        out_valid;
  logic        out_ready;
  logic        out_sign;
  logic [9:0]  out_exp;
  logic [23:0] out_man;
  logic [3:0]  out_flags;

  int errors = 0;
  int checks = 0;

  fp_norm_round #(.WIDTH(24), .EXP_W(10), .EXT(3)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sign   (in_sign),
    .in_exp    (in_exp),
    .in_man    (in_man),
    .in_lz     (in_lz),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sign  (out_sign),
    .out_exp   (out_exp),
    .out_man   (out_man),
    .out_flags (out_flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference: value-level shift, then round the 3 dropped bits as a fraction of 8.
  function automatic res_t model(input vec_t v);
    res_t   r;
    longint mv;
    longint q;
    int     ev;
    int     s;
    int     rem;
    bit     zero;
    bit     tiny;
    bit     inexact;
    zero = (v.lz == 6'd24);
    ev   = int'(v.exp);
    s    = 0;
    if (!zero && ev > 1) s = (int'(v.lz) < ev - 1) ? int'(v.lz) : ev - 1;
    mv   = longint'(v.man);
    mv   = (s > 40) ? 0 : (mv << s) % (longint'(1) << 27);
    tiny = mv < (longint'(1) << 26);
    ev   = tiny ? 0 : ev - s;
    q    = mv / 8;
    rem  = int'(mv % 8);
    inexact = (rem != 0);
`ifdef FP_NORM_RNE_EN
    if (!zero && (rem > 4 || (rem == 4 && (q % 2) == 1))) q = q + 1;
    if (q == (longint'(1) << 24)) begin
      q  = longint'(1) << 23;
      ev = ev + 1;
    end else if (tiny && q >= (longint'(1) << 23)) begin
      ev   = 1;
      tiny = 0;
    end
`endif
    r.sign  = v.sign;
    r.flags = {1'b0, tiny && inexact, inexact, zero};
    if (ev >= 1023) begin
      r.flags[3] = 1'b1;
      ev = 1023;
      q  = 0;
    end
    r.exp = 10'(ev);
    r.man = 24'(q);
    return r;
  endfunction

  function automatic vec_t mk(input logic s, input int e, input logic [23:0] m,
                              input logic [2:0] grs, input int lz);
    vec_t v;
    v.sign = s;
    v.exp  = 10'(e);
    v.man  = {m, grs};
    v.lz   = 6'(lz);
    return v;
  endfunction

  function automatic vec_t rand_vec();
    vec_t        v;
    int          lz;
    logic [23:0] m;
    logic [23:0] low;
    lz = ($urandom_range(0, 9) == 0) ? 24 : int'($urandom_range(0, 23));
    if (lz == 24) begin
      m = '0;
    end else begin
      low = (24'h1 << (23 - lz)) - 24'h1;
      m   = 24'($urandom) & low;
      if ($urandom_range(0, 5) == 0) m = low;
      m = m | (24'h1 << (23 - lz));
    end
    case ($urandom_range(0, 3))
      0:       v.exp = 10'($urandom_range(0, 8));
      1:       v.exp = 10'($urandom_range(1000, 1023));
      default: v.exp = 10'($urandom_range(1, 1023));
    endcase
    v.sign = 1'($urandom);
    v.man  = {m, 3'($urandom)};
    v.lz   = 6'(lz);
    return v;
  endfunction

  function automatic string fmt(input res_t r);
    return $sformatf("s=%0b e=%h m=%h f=%b", r.sign, r.exp, r.man, r.flags);
  endfunction

  function automatic res_t cap();
    return {out_sign, out_exp, out_man, out_flags};
  endfunction

  task automatic drive(input vec_t v);
    in_sign = v.sign;
    in_exp  = v.exp;
    in_man  = v.man;
    in_lz   = v.lz;
  endtask

  // Single beat through an empty pipe; reports out_valid one and two edges later.
  task automatic run_single(input vec_t v, output res_t got, output logic early,
                            output logic late);
    @(negedge clk);
    drive(v);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    early    = out_valid;
    @(negedge clk);
    late = out_valid;
    got  = cap();
  endtask

  task automatic test_reset();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    drive('0);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_handshake: out_valid=%b in_ready=%b, expected 0/1", out_valid, in_ready);
    end
    checks++;
    if (cap() !== res_t'(0)) begin
      errors++;
      $display("FAIL reset_outputs: got %s, expected all zero", fmt(cap()));
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release: out_valid=%b in_ready=%b, expected 0/1", out_valid, in_ready);
    end
  endtask

  task automatic test_directed();
    vec_t  v[9];
    res_t  want[9];
    string name[9];
    res_t  got;
    res_t  ref_r;
    logic  early;
    logic  late;
    v[0] = mk(0, 20, 24'h0C0000, 3'b000, 4);     name[0] = "t1_basic";
    v[1] = mk(0, 5, 24'h002000, 3'b000, 10);     name[1] = "t2_sub_exact";
    v[2] = mk(0, 2, 24'h002000, 3'b011, 10);     name[2] = "t2_sub_inexact";
    v[3] = mk(1, 100, 24'hFFFFFF, 3'b100, 0);    name[3] = "t3_carry";
    v[4] = mk(0, 50, 24'h000000, 3'b000, 24);    name[4] = "t4_zero";
    v[5] = mk(0, 1023, 24'h800000, 3'b000, 0);   name[5] = "t4_ovf";
    v[6] = mk(0, 7, 24'h000000, 3'b101, 24);     name[6] = "zero_grs";
    v[7] = mk(0, 1, 24'h7FFFFF, 3'b111, 1);      name[7] = "sub_to_norm";
    v[8] = mk(0, 100, 24'h800000, 3'b100, 0);    name[8] = "tie_even";
    want[0] = {1'b0, 10'd16, 24'hC00000, 4'b0000};
    want[1] = {1'b0, 10'd0, 24'h020000, 4'b0000};
`ifdef FP_NORM_RNE_EN
    want[2] = {1'b0, 10'd0, 24'h004001, 4'b0110};
    want[3] = {1'b1, 10'd101, 24'h800000, 4'b0010};
    want[7] = {1'b0, 10'd1, 24'h800000, 4'b0010};
`else
    want[2] = {1'b0, 10'd0, 24'h004000, 4'b0110};
    want[3] = {1'b1, 10'd100, 24'hFFFFFF, 4'b0010};
    want[7] = {1'b0, 10'd0, 24'h7FFFFF, 4'b0110};
`endif
    want[4] = {1'b0, 10'd0, 24'h000000, 4'b0001};
    want[5] = {1'b0, 10'h3FF, 24'h000000, 4'b1000};
    want[6] = {1'b0, 10'd0, 24'h000000, 4'b0111};
    want[8] = {1'b0, 10'd100, 24'h800000, 4'b0010};
    for (int i = 0; i < 9; i++) begin
      run_single(v[i], got, early, late);
      checks++;
      if (early !== 1'b0 || late !== 1'b1) begin
        errors++;
        $display("FAIL %s_latency: out_valid after 1/2 edges=%b/%b, expected 0/1", name[i], early, late);
      end
      checks++;
      if (got !== want[i]) begin
        errors++;
        $display("FAIL %s: got %s, expected %s", name[i], fmt(got), fmt(want[i]));
      end
      ref_r = model(v[i]);
      checks++;
      if (got !== ref_r) begin
        errors++;
        $display("FAIL %s_model: got %s, expected %s", name[i], fmt(got), fmt(ref_r));
      end
    end
  endtask

  task automatic test_full_rate();
    vec_t v[16];
    res_t want;
    for (int i = 0; i < 16; i++) v[i] = rand_vec();
    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      out_ready = 1'b1;
      in_valid  = (i < 16);
      if (i < 16) drive(v[i]);
      #1;
      if (i < 16) begin
        checks++;
        if (in_ready !== 1'b1) begin
          errors++;
          $display("FAIL full_rate_ready: cycle %0d in_ready=%b, expected 1", i, in_ready);
        end
      end
      if (i >= 2) begin
        want = model(v[i-2]);
        checks++;
        if (out_valid !== 1'b1 || cap() !== want) begin
          errors++;
          $display("FAIL full_rate_beat%0d: valid=%b got %s, expected %s", i - 2, out_valid, fmt(cap()), fmt(want));
        end
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_back_to_back();
    vec_t v[8];
    res_t want;
    int   sent = 0;
    int   rcvd = 0;
    int   cyc  = 0;
    for (int i = 0; i < 8; i++) v[i] = rand_vec();
    while (rcvd < 8 && cyc < 200) begin
      @(negedge clk);
      out_ready = 1'($urandom_range(0, 1));
      in_valid  = (sent < 8);
      if (sent < 8) drive(v[sent]);
      #1;
      if (in_valid && in_ready) sent++;
      if (out_valid && out_ready) begin
        want = model(v[rcvd]);
        checks++;
        if (cap() !== want) begin
          errors++;
          $display("FAIL b2b_beat%0d: got %s, expected %s", rcvd, fmt(cap()), fmt(want));
        end
        rcvd++;
      end
      cyc++;
    end
    in_valid = 1'b0;
    checks++;
    if (rcvd != 8) begin
      errors++;
      $display("FAIL b2b_count: received %0d beats, expected 8", rcvd);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL b2b_extra: out_valid=%b after drain, expected 0", out_valid);
      end
    end
  endtask

  task automatic test_random();
    localparam int N = 300;
    res_t q[$];
    res_t want;
    res_t held;
    vec_t cur;
    bit   have    = 0;
    bit   stalled = 0;
    int   sent    = 0;
    int   rcvd    = 0;
    int   cyc     = 0;
    held = '0;
    cur  = '0;
    while (rcvd < N && cyc < N * 20) begin
      @(negedge clk);
      if (stalled) begin
        checks++;
        if (out_valid !== 1'b1 || cap() !== held) begin
          errors++;
          $display("FAIL rand_hold: valid=%b got %s, expected %s", out_valid, fmt(cap()), fmt(held));
        end
      end
      if (!have && sent < N && $urandom_range(0, 3) != 0) begin
        cur  = rand_vec();
        have = 1;
      end
      in_valid = have;
      if (have) drive(cur);
      out_ready = ($urandom_range(0, 9) < 7);
      #1;
      if (in_valid && in_ready) begin
        q.push_back(model(cur));
        have = 0;
        sent++;
      end
      if (out_valid && out_ready) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL rand_unexpected: got %s with no beat outstanding", fmt(cap()));
        end else begin
          want = q.pop_front();
          if (cap() !== want) begin
            errors++;
            $display("FAIL rand_beat%0d: got %s, expected %s", rcvd, fmt(cap()), fmt(want));
          end
        end
        rcvd++;
      end
      stalled = out_valid && !out_ready;
      if (stalled) held = cap();
      cyc++;
    end
    in_valid = 1'b0;
    checks++;
    if (rcvd != N || q.size() != 0) begin
      errors++;
      $display("FAIL rand_count: received %0d beats (%0d pending), expected %0d", rcvd, q.size(), N);
    end
  endtask

  task automatic test_reset_flight();
    bit seen = 0;
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    drive(rand_vec());
    @(negedge clk);
    drive(rand_vec());
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL flight_full: out_valid=%b in_ready=%b, expected 1/0", out_valid, in_ready);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || cap() !== res_t'(0)) begin
      errors++;
      $display("FAIL flight_async: out_valid=%b in_ready=%b out %s, expected 0/1 zeros", out_valid, in_ready, fmt(cap()));
    end
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (out_valid !== 1'b0) seen = 1;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL flight_stale: out_valid=1 after reset release, expected 0");
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    test_reset();
    test_directed();
    test_full_rate();
    test_back_to_back();
    test_random();
    test_reset_flight();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
